chacha_poly1305_seq: RTL and testbench
======================================

// Module: chacha_poly1305_seq
// PURPOSE
//  Sequencer for the ChaCha20-Poly1305 MAC engine (A1 flow: one AAD block, N payload blocks, one LEN block).
//  Takes a command (AAD/payload byte counts) and a 128-bit host word stream, then drives the engine's
//  start/aad/pld/len handshakes. Builds tail keep masks and the length block, and captures the tag.
//  Sits between the cfg/DMA front-end and the MAC engine. Only one block is ever outstanding in the engine.
// PARAMETERS
//  PLD_LEN_W    32    width of payload byte count (max 2^32-1 bytes)
//  TIMEOUT_CYC  1024  watchdog limit in cycles per engine wait state (used only with SEQ_TIMEOUT_EN)
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    async active-low reset
//  cmd_start      in   1    1-cycle command strobe; sampled only in IDLE
//  cmd_aad_bytes  in   5    AAD byte count, legal 1..16
//  cmd_pld_bytes  in   PLD_LEN_W  payload byte count, 0 legal
//  in_valid       in   1    host word valid
//  in_data        in   128  host word (AAD word first, then payload words)
//  in_ready       out  1    host word accepted when in_valid&in_ready
//  eng_start      out  1    1-cycle start pulse to engine (algo_sel tied high outside)
//  eng_aad_valid/eng_aad_data[127:0]/eng_aad_keep[15:0]  out  AAD block to engine
//  eng_aad_ready, eng_aad_done                           in   engine accept / block-done pulse
//  eng_pld_valid/eng_pld_data[127:0]/eng_pld_keep[15:0]  out  payload block
//  eng_pld_ready, eng_pld_done                           in
//  eng_len_valid/eng_len_block[127:0]                    out  length block
//  eng_len_ready, eng_lens_done                          in
//  eng_tag        in   128  engine tag_pre_xor
//  eng_tag_valid  in   1    engine tag strobe
//  busy           out  1    high from accepted cmd_start until tag_valid
//  tag_out        out  128  captured tag, held until next capture
//  tag_valid      out  1    1-cycle pulse when tag_out updates
//  err            out  1    1-cycle pulse: illegal command or watchdog timeout
// BEHAVIOUR
//  Reset: all outputs 0, tag_out=0, state=IDLE, counters/holding register cleared. Reset mid-operation aborts silently.
//  States: IDLE -> START -> AAD_GET -> AAD_ISS -> AAD_WT -> {PLD_GET -> PLD_ISS -> PLD_WT}* -> LEN_ISS -> LEN_WT -> TAG_WT -> IDLE.
//  IDLE: cmd_start with aad_bytes in 1..16: latch counts, set blk_left=ceil(pld/16), busy<=1, go to START.
//        cmd_start with aad_bytes 0 or >16: err pulse next cycle, stay IDLE. cmd_start outside IDLE: ignored.
//  START: eng_start=1 for exactly one cycle, then AAD_GET.
//  *_GET: in_ready=1 (registered). A handshake captures in_data into hold; bytes at or above the keep count are zeroed.
//  *_ISS: eng_x_valid=1 with hold/keep until eng_x_ready=1 seen high in the same cycle. Then *_WT; valid drops the next cycle.
//  *_WT: wait for the eng_x_done pulse. Done before or in the ISS cycle is not possible; a done seen outside WT is ignored.
//  After AAD_WT: blk_left==0 -> LEN_ISS, else PLD_GET. After PLD_WT: decrement blk_left; 0 -> LEN_ISS, else PLD_GET.
//  Keep: AAD keep=(1<<aad_bytes)-1 (16 -> 16'hFFFF). Payload keep is 16'hFFFF except on the last block,
//        where rem=pld%16 and rem!=0 gives (1<<rem)-1.
//  Len block: [63:0]=zero-extended aad_bytes, [127:64]=zero-extended pld_bytes (little-endian Poly1305 layout).
//  TAG_WT: on eng_tag_valid, tag_out<=eng_tag, tag_valid pulse, busy<=0, go to IDLE in the same edge.
//  Host stalls (in_valid=0) are unbounded and never time out. in_ready is never high outside *_GET.
//  Latency: eng_start 2 cycles after cmd_start; in_ready high 1 cycle after entering *_GET.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: a cycle counter clears on entry to each *_ISS/*_WT/TAG_WT state.
//    Reaching TIMEOUT_CYC -> err pulse, all eng_* valids drop, busy<=0, go to IDLE. No tag is produced.
//  SEQ_TIMEOUT_EN undefined: no counter; the sequencer waits forever; err only for illegal commands.
// TESTING
//  1. aad=16, pld=32, 3 words, engine ready/done after 3 cyc -> 1 aad + 2 pld (keep FFFF), len={64'd32,64'd16}, tag_valid once.
//  2. aad=5, pld=20 -> aad_keep=001F, pld keeps FFFF then 000F, upper bytes zero, len={64'd20,64'd5}.
//  3. aad=1, pld=0 -> AAD then LEN directly; no eng_pld_valid ever; len={64'd0,64'd1}.
//  4. cmd aad=0 and aad=17 -> err pulse each, eng_start never asserted; cmd_start during busy ignored.
//  5. Random in_valid/eng_ready stalls + rst_n low mid-payload -> outputs 0 immediately; next cmd completes correctly.
//  6. SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, withhold eng_pld_done -> err at 16 cyc, busy=0, IDLE, no tag_valid.

Source files
------------

// File: rtl/chacha_poly1305_seq.sv
// chacha_poly1305_seq: sequencer for the ChaCha20-Poly1305 MAC engine.
// It runs one AAD block, N payload blocks and one length block. Only one block is
// outstanding in the engine at any time.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_start/aad/pld_bytes    command strobe and byte counts (sampled only in IDLE)
//   in_valid/in_data/in_ready  128-bit host word stream (AAD word first, then payload)
//   eng_start                  1-cycle start pulse to the engine
//   eng_aad_* / eng_pld_*      block valid/data/keep out; ready and done pulse in
//   eng_len_*                  length block valid/data out; ready and lens_done in
//   eng_tag, eng_tag_valid     tag from the engine
//   busy, tag_out, tag_valid   status, captured tag, and tag update pulse
//   err                        1-cycle pulse on an illegal command (or watchdog timeout)
//
// Optional feature: define SEQ_TIMEOUT_EN to enable a per-wait-state watchdog of
// TIMEOUT_CYC cycles.
module chacha_poly1305_seq #(
  parameter int unsigned PLD_LEN_W   = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_start,
  input  logic [4:0]           cmd_aad_bytes,
  input  logic [PLD_LEN_W-1:0] cmd_pld_bytes,
  input  logic                 in_valid,
  input  logic [127:0]         in_data,
  output logic                 in_ready,
  output logic                 eng_start,
  output logic                 eng_aad_valid,
  output logic [127:0]         eng_aad_data,
  output logic [15:0]          eng_aad_keep,
  input  logic                 eng_aad_ready,
  input  logic                 eng_aad_done,
  output logic                 eng_pld_valid,
  output logic [127:0]         eng_pld_data,
  output logic [15:0]          eng_pld_keep,
  input  logic                 eng_pld_ready,
  input  logic                 eng_pld_done,
  output logic                 eng_len_valid,
  output logic [127:0]         eng_len_block,
  input  logic                 eng_len_ready,
  input  logic                 eng_lens_done,
  input  logic [127:0]         eng_tag,
  input  logic                 eng_tag_valid,
  output logic                 busy,
  output logic [127:0]         tag_out,
  output logic                 tag_valid,
  output logic                 err
);

  typedef enum logic [3:0] {
    StIdle, StStart, StAadGet, StAadIss, StAadWt, StPldGet, StPldIss, StPldWt,
    StLenIss, StLenWt, StTagWt
  } state_e;

  state_e                 state_q, state_d;
  logic [4:0]             aad_q, aad_d;
  logic [PLD_LEN_W-1:0]   pld_q, pld_d, blk_q, blk_d;
  logic [127:0]           hold_q, hold_d, tag_q, tag_d;
  logic [15:0]            keep_q, keep_d, aad_keep, pld_keep;
  logic                   in_ready_q, in_ready_d, start_q, start_d, busy_q, busy_d;
  logic                   aad_valid_q, aad_valid_d, pld_valid_q, pld_valid_d;
  logic                   len_valid_q, len_valid_d, tag_valid_q, tag_valid_d, err_q, err_d;
  logic                   hs_in;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timed;
`endif

  // Zero every byte lane whose keep bit is clear.
  function automatic logic [127:0] mask_data(input logic [127:0] d, input logic [15:0] k);
    for (int i = 0; i < 16; i++) mask_data[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
  endfunction

  assign hs_in    = in_valid & in_ready_q;
  assign aad_keep = 16'hFFFF >> (5'd16 - aad_q);

  // Only the final payload block (blk_left == 1) can be partial.
  always_comb begin
    pld_keep = 16'hFFFF;
    if (blk_q == PLD_LEN_W'(1) && pld_q[3:0] != 4'd0) begin
      pld_keep = 16'hFFFF >> (5'd16 - {1'b0, pld_q[3:0]});
    end
  end

  always_comb begin
    state_d     = state_q;
    aad_d       = aad_q;
    pld_d       = pld_q;
    blk_d       = blk_q;
    hold_d      = hold_q;
    keep_d      = keep_q;
    busy_d      = busy_q;
    tag_d       = tag_q;
    tag_valid_d = 1'b0;
    err_d       = 1'b0;
    start_d     = 1'b0;
    in_ready_d  = 1'b0;
    aad_valid_d = 1'b0;
    pld_valid_d = 1'b0;
    len_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          if (cmd_aad_bytes != 5'd0 && cmd_aad_bytes <= 5'd16) begin
            aad_d   = cmd_aad_bytes;
            pld_d   = cmd_pld_bytes;
            blk_d   = (cmd_pld_bytes >> 4) + PLD_LEN_W'(|cmd_pld_bytes[3:0]);
            busy_d  = 1'b1;
            state_d = StStart;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StStart: begin
        start_d = 1'b1;
        state_d = StAadGet;
      end
      StAadGet, StPldGet: begin
        // in_ready is registered, so it rises one cycle after entering and drops on accept.
        in_ready_d = ~hs_in;
        if (hs_in) begin
          keep_d  = (state_q == StAadGet) ? aad_keep : pld_keep;
          hold_d  = mask_data(in_data, keep_d);
          state_d = (state_q == StAadGet) ? StAadIss : StPldIss;
        end
      end
      StAadIss: begin
        if (aad_valid_q && eng_aad_ready) state_d = StAadWt;
        else aad_valid_d = 1'b1;
      end
      StAadWt: begin
        if (eng_aad_done) state_d = (blk_q == '0) ? StLenIss : StPldGet;
      end
      StPldIss: begin
        if (pld_valid_q && eng_pld_ready) state_d = StPldWt;
        else pld_valid_d = 1'b1;
      end
      StPldWt: begin
        if (eng_pld_done) begin
          blk_d   = blk_q - PLD_LEN_W'(1);
          state_d = (blk_q == PLD_LEN_W'(1)) ? StLenIss : StPldGet;
        end
      end
      StLenIss: begin
        if (len_valid_q && eng_len_ready) state_d = StLenWt;
        else len_valid_d = 1'b1;
      end
      StLenWt: begin
        if (eng_lens_done) state_d = StTagWt;
      end
      StTagWt: begin
        if (eng_tag_valid) begin
          tag_d       = eng_tag;
          tag_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef SEQ_TIMEOUT_EN
    timed = state_q inside {StAadIss, StAadWt, StPldIss, StPldWt, StLenIss, StLenWt, StTagWt};
    if (timed && state_d == state_q && cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
      state_d     = StIdle;
      err_d       = 1'b1;
      busy_d      = 1'b0;
      aad_valid_d = 1'b0;
      pld_valid_d = 1'b0;
      len_valid_d = 1'b0;
    end
    // Counter restarts whenever a timed state is (re)entered.
    cnt_d = (timed && state_d == state_q) ? cnt_q + CntW'(1) : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      aad_q       <= '0;
      pld_q       <= '0;
      blk_q       <= '0;
      hold_q      <= '0;
      keep_q      <= '0;
      busy_q      <= 1'b0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      aad_valid_q <= 1'b0;
      pld_valid_q <= 1'b0;
      len_valid_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      aad_q       <= aad_d;
      pld_q       <= pld_d;
      blk_q       <= blk_d;
      hold_q      <= hold_d;
      keep_q      <= keep_d;
      busy_q      <= busy_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      err_q       <= err_d;
      start_q     <= start_d;
      in_ready_q  <= in_ready_d;
      aad_valid_q <= aad_valid_d;
      pld_valid_q <= pld_valid_d;
      len_valid_q <= len_valid_d;
`ifdef SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign eng_start     = start_q;
  assign eng_aad_valid = aad_valid_q;
  assign eng_aad_data  = hold_q;
  assign eng_aad_keep  = keep_q;
  assign eng_pld_valid = pld_valid_q;
  assign eng_pld_data  = hold_q;
  assign eng_pld_keep  = keep_q;
  assign eng_len_valid = len_valid_q;
  // Little-endian Poly1305 length block: AAD length low, payload length high.
  assign eng_len_block = {64'(pld_q), 64'(aad_q)};
  assign busy          = busy_q;
  assign tag_out       = tag_q;
  assign tag_valid     = tag_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_chacha_poly1305_seq.sv
module tb_chacha_poly1305_seq;
`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TbTimeout = 16;
`else
  localparam int unsigned TbTimeout = 1024;
`endif

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         cmd_start = 1'b0;
  logic [4:0]   cmd_aad_bytes = '0;
  logic [31:0]  cmd_pld_bytes = '0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, eng_start, eng_aad_valid, eng_pld_valid, eng_len_valid;
  logic [127:0] eng_aad_data, eng_pld_data, eng_len_block, tag_out;
  logic [15:0]  eng_aad_keep, eng_pld_keep;
  logic         eng_aad_ready = 0, eng_aad_done = 0, eng_pld_ready = 0, eng_pld_done = 0;
  logic         eng_len_ready = 0, eng_lens_done = 0, eng_tag_valid = 0;
  logic [127:0] eng_tag = '0;
  logic         busy, tag_valid, err;

  chacha_poly1305_seq #(.PLD_LEN_W(32), .TIMEOUT_CYC(TbTimeout)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_aad_bytes(cmd_aad_bytes),
    .cmd_pld_bytes(cmd_pld_bytes), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .eng_start(eng_start), .eng_aad_valid(eng_aad_valid), .eng_aad_data(eng_aad_data),
    .eng_aad_keep(eng_aad_keep), .eng_aad_ready(eng_aad_ready), .eng_aad_done(eng_aad_done),
    .eng_pld_valid(eng_pld_valid), .eng_pld_data(eng_pld_data), .eng_pld_keep(eng_pld_keep),
    .eng_pld_ready(eng_pld_ready), .eng_pld_done(eng_pld_done), .eng_len_valid(eng_len_valid),
    .eng_len_block(eng_len_block), .eng_len_ready(eng_len_ready),
    .eng_lens_done(eng_lens_done), .eng_tag(eng_tag), .eng_tag_valid(eng_tag_valid),
    .busy(busy), .tag_out(tag_out), .tag_valid(tag_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   kind;  // 0 aad, 1 payload, 2 length
    logic [127:0] data;
    logic [15:0]  keep;
  } item_t;

  item_t        exp_q[$];
  logic [127:0] words[$];
  logic [15:0]  pld_keeps[$];
  logic [127:0] exp_tag = '0, last_len = '0;
  logic [15:0]  last_aad_keep = '0;
  int checks = 0, failures = 0;
  int n_start = 0, n_err = 0, n_tag = 0, n_aad = 0, n_pld = 0, n_len = 0;
  bit rand_mode = 0, hold_pld_done = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: what the engine must receive for a command, from the byte counts alone.
  function automatic logic [15:0] keep_of(input int n);
    int k;
    k = (n >= 16) ? 32'hFFFF : ((1 << n) - 1);
    return k[15:0];
  endfunction

  function automatic logic [127:0] cut(input logic [127:0] d, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (i < n) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Engine model: one block at a time, ready after a latency, done after another.
  int ph = 0, ecnt = 0, ekind = 0;
  function automatic int lat();
    return rand_mode ? int'($urandom_range(0, 4)) : 3;
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ph = 0;
        {eng_aad_ready, eng_pld_ready, eng_len_ready} = '0;
        {eng_aad_done, eng_pld_done, eng_lens_done, eng_tag_valid} = '0;
      end else begin
        case (ph)
          0: begin
            if (eng_aad_valid) begin ekind = 0; ecnt = lat(); ph = 1; end
            else if (eng_pld_valid) begin ekind = 1; ecnt = lat(); ph = 1; end
            else if (eng_len_valid) begin ekind = 2; ecnt = lat(); ph = 1; end
          end
          1: if (ecnt > 0) ecnt--;
             else begin
               eng_aad_ready = (ekind == 0); eng_pld_ready = (ekind == 1);
               eng_len_ready = (ekind == 2); ph = 2;
             end
          2: begin {eng_aad_ready, eng_pld_ready, eng_len_ready} = '0; ecnt = lat(); ph = 3; end
          3: if (ekind == 1 && hold_pld_done) ecnt = 0;
             else if (ecnt > 0) ecnt--;
             else begin
               eng_aad_done = (ekind == 0); eng_pld_done = (ekind == 1);
               eng_lens_done = (ekind == 2); ph = 4;
             end
          4: begin
            {eng_aad_done, eng_pld_done, eng_lens_done} = '0;
            if (ekind == 2) begin ecnt = lat(); ph = 5; end else ph = 0;
          end
          5: if (ecnt > 0) ecnt--; else begin eng_tag = exp_tag; eng_tag_valid = 1; ph = 6; end
          default: begin eng_tag_valid = 0; eng_tag = ~exp_tag; ph = 0; end
        endcase
      end
    end
  end

  // Compare process: every cycle a block is presented it must match the model's next item.
  task automatic cmp_blk(input string nm, input logic [1:0] k, input logic [127:0] d,
                         input logic [15:0] kp, input bit hs);
    item_t e;
    if (exp_q.size() == 0) begin
      chk({nm, "_unexpected"}, 128'(1), 128'(0));
    end else begin
      e = exp_q[0];
      chk({nm, "_kind"}, 128'(k), 128'(e.kind));
      chk({nm, "_data"}, d, e.data);
      if (k != 2'd2) chk({nm, "_keep"}, 128'(kp), 128'(e.keep));
      if (hs) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (int'(eng_aad_valid) + int'(eng_pld_valid) + int'(eng_len_valid) > 1)
          chk("one_valid", 128'(0), 128'(1));
        if (in_ready) chk("in_ready_needs_busy", 128'(busy), 128'(1));
        if (eng_aad_valid) begin
          cmp_blk("aad", 2'd0, eng_aad_data, eng_aad_keep, eng_aad_ready);
          if (eng_aad_ready) begin n_aad++; last_aad_keep = eng_aad_keep; end
        end
        if (eng_pld_valid) begin
          cmp_blk("pld", 2'd1, eng_pld_data, eng_pld_keep, eng_pld_ready);
          if (eng_pld_ready) begin n_pld++; pld_keeps.push_back(eng_pld_keep); end
        end
        if (eng_len_valid) begin
          cmp_blk("len", 2'd2, eng_len_block, 16'h0, eng_len_ready);
          if (eng_len_ready) begin n_len++; last_len = eng_len_block; end
        end
        if (eng_start) n_start++;
        if (err) n_err++;
        if (tag_valid) begin
          chk("tag_value", tag_out, exp_tag);
          chk("tag_after_all_blocks", 128'(exp_q.size()), 128'(0));
          n_tag++;
        end
      end
    end
  end

  task automatic issue_cmd(input logic [4:0] a, input logic [31:0] p);
    cmd_aad_bytes = a; cmd_pld_bytes = p; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic send_word(input string nm, input logic [127:0] w);
    bit acc = 0;
    for (int i = 0; i < 300 && !acc; i++) begin
      in_valid = !(rand_mode && $urandom_range(0, 2) == 0);
      in_data  = w;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk({nm, "_word_timeout"}, 128'(0), 128'(1));
  endtask

  // Builds the model's expectations, then runs one command end to end.
  task automatic prep(input logic [4:0] a, input logic [31:0] p);
    int nb;
    logic [127:0] w;
    nb = (int'(p) + 15) / 16;
    exp_q.delete(); words.delete(); pld_keeps.delete();
    exp_tag = {$urandom, $urandom, $urandom, $urandom};
    w = {$urandom | 32'h01010101, $urandom | 32'h01010101, $urandom | 32'h01010101,
         $urandom | 32'h01010101};
    words.push_back(w);
    exp_q.push_back('{kind: 2'd0, data: cut(w, int'(a)), keep: keep_of(int'(a))});
    for (int b = 0; b < nb; b++) begin
      int n;
      n = int'(p) - 16 * b;
      if (n > 16) n = 16;
      w = {$urandom | 32'h80808080, $urandom, $urandom | 32'h80808080, $urandom};
      words.push_back(w);
      exp_q.push_back('{kind: 2'd1, data: cut(w, n), keep: keep_of(n)});
    end
    exp_q.push_back('{kind: 2'd2, data: {64'(p), 64'(a)}, keep: 16'h0});
  endtask

  task automatic run_cmd(input string nm, input logic [4:0] a, input logic [31:0] p,
                         input bit poke);
    int t0;
    prep(a, p);
    issue_cmd(a, p);
    chk({nm, "_busy_set"}, 128'(busy), 128'(1));
    foreach (words[i]) begin
      send_word(nm, words[i]);
      if (poke && i == 0) issue_cmd(5'd0, 32'd0);
    end
    t0 = n_tag;
    for (int i = 0; i < 3000 && n_tag == t0; i++) begin @(posedge clk); #1; end
    chk({nm, "_tag_count"}, 128'(n_tag - t0), 128'(1));
    chk({nm, "_busy_clear"}, 128'(busy), 128'(0));
  endtask

  int s0, e0, a0, p0, l0, t0;

  initial begin
    #1;
    chk("reset_outputs", 128'({in_ready, eng_start, eng_aad_valid, eng_pld_valid,
        eng_len_valid, busy, tag_valid, err}), 128'(0));
    chk("reset_tag", tag_out, 128'(0));
    chk("reset_len", eng_len_block, 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: full blocks; eng_start lands two cycles after cmd_start.
    s0 = n_start; a0 = n_aad; p0 = n_pld; t0 = n_tag;
    prep(5'd16, 32'd32);
    issue_cmd(5'd16, 32'd32);
    chk("t1_start_early", 128'(eng_start), 128'(0));
    @(posedge clk); #1;
    chk("t1_start_latency", 128'(eng_start), 128'(1));
    foreach (words[i]) send_word("t1", words[i]);
    for (int i = 0; i < 500 && n_tag == t0; i++) begin @(posedge clk); #1; end
    chk("t1_counts", 128'({8'(n_start - s0), 8'(n_aad - a0), 8'(n_pld - p0), 8'(n_tag - t0)}),
        128'(32'h01_01_02_01));
    chk("t1_len", last_len, 128'h0000000000000020_0000000000000010);
    chk("t1_keeps", 128'({pld_keeps[0], pld_keeps[1]}), 128'(32'hFFFF_FFFF));

    // 2: partial AAD and tail payload; a command while busy must be ignored.
    s0 = n_start; e0 = n_err;
    run_cmd("t2", 5'd5, 32'd20, 1'b1);
    chk("t2_aad_keep", 128'(last_aad_keep), 128'(16'h001F));
    chk("t2_pld_keeps", 128'({pld_keeps[0], pld_keeps[1]}), 128'(32'hFFFF_000F));
    chk("t2_len", last_len, 128'h0000000000000014_0000000000000005);
    chk("t2_busy_cmd_ignored", 128'({8'(n_start - s0), 8'(n_err - e0)}), 128'(16'h0100));

    // 3: no payload; AAD goes straight to the length block.
    p0 = n_pld; l0 = n_len;
    run_cmd("t3", 5'd1, 32'd0, 1'b0);
    chk("t3_no_pld", 128'(n_pld - p0), 128'(0));
    chk("t3_len", last_len, 128'h0000000000000000_0000000000000001);
    chk("t3_len_count", 128'(n_len - l0), 128'(1));

    // 4: illegal AAD counts.
    s0 = n_start; e0 = n_err;
    issue_cmd(5'd0, 32'd16);
    chk("t4_err_aad0", 128'(err), 128'(1));
    @(posedge clk); #1;
    chk("t4_err_one_cycle", 128'(err), 128'(0));
    issue_cmd(5'd17, 32'd16);
    chk("t4_err_aad17", 128'(err), 128'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("t4_no_start", 128'({8'(n_start - s0), 8'(n_err - e0), 7'd0, busy}), 128'(24'h00_02_00));

    // 5: random stalls, reset mid-payload, then a clean command.
    rand_mode = 1;
    prep(5'd8, 32'd40);
    issue_cmd(5'd8, 32'd40);
    send_word("t5a", words[0]);
    send_word("t5a", words[1]);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", 128'({in_ready, eng_start, eng_aad_valid, eng_pld_valid,
        eng_len_valid, busy, tag_valid, err}), 128'(0));
    chk("t5_reset_len", eng_len_block, 128'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd("t5b", 5'd12, 32'd45, 1'b0);
    chk("t5b_last_keep", 128'(pld_keeps[pld_keeps.size() - 1]), 128'(16'h1FFF));

`ifdef SEQ_TIMEOUT_EN
    // 6: withheld payload done trips the watchdog.
    rand_mode = 0; hold_pld_done = 1;
    e0 = n_err; t0 = n_tag;
    prep(5'd4, 32'd16);
    issue_cmd(5'd4, 32'd16);
    send_word("t6", words[0]);
    send_word("t6", words[1]);
    for (int i = 0; i < 100 && n_err == e0; i++) begin @(posedge clk); #1; end
    chk("t6_err", 128'(n_err - e0), 128'(1));
    chk("t6_state", 128'({busy, eng_aad_valid, eng_pld_valid, eng_len_valid}), 128'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_tag", 128'(n_tag - t0), 128'(0));
    hold_pld_done = 0;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
